// File: rtl/psram_burst_arbiter.sv
// psram_burst_arbiter: two-requester burst arbiter for one PSRAM controller channel.
// Define ARB_READ_PRIORITY_EN for fixed read priority on ties; default is round-robin.
module psram_burst_arbiter #(
  parameter int ADDR_WIDTH  = 21,
  parameter int BURST_WORDS = 4,
  parameter int CMD_GAP     = 14,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done_i,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  output logic                  wr_ack_o,
  output logic                  wr_data_rd_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ack_o,
  output logic [31:0]           rd_data_o,
  output logic                  rd_data_valid_o,
  output logic                  mem_cmd_o,
  output logic                  mem_cmd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic [3:0]            mem_data_mask_o,
  input  logic [31:0]           mem_rd_data_i,
  input  logic                  mem_rd_data_valid_i,
  output logic                  error_o
);
  localparam int CW = $clog2((CMD_GAP > RD_TIMEOUT ? CMD_GAP : RD_TIMEOUT) + 2);
  localparam int BW = $clog2(BURST_WORDS + 1);
  typedef enum logic [2:0] {WAIT_INIT, IDLE, WRITE, READ, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, error_q, error_d, grant_wr;
`ifdef ARB_READ_PRIORITY_EN
  assign grant_wr = wr_req_i & ~rd_req_i;
`else
  logic last_wr_q;
  assign grant_wr = wr_req_i & (~rd_req_i | ~last_wr_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_wr_q <= 1'b0;
    else if (state_q == IDLE && (wr_req_i || rd_req_i)) last_wr_q <= grant_wr;
`endif
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;
  assign error_o         = error_q;
  assign mem_data_mask_o = 4'h0;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CW'(cnt_q != '1);
    beat_d        = beat_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    error_d       = error_q;
    wr_ack_o      = 1'b0;
    wr_data_rd_o  = 1'b0;
    rd_ack_o      = 1'b0;
    mem_cmd_o     = 1'b0;
    mem_cmd_en_o  = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    unique case (state_q)
      WAIT_INIT: state_d = init_done_i ? IDLE : WAIT_INIT;
      IDLE: if (wr_req_i || rd_req_i) begin
        state_d = grant_wr ? WRITE : READ;
        cnt_d   = '0;
        beat_d  = '0;
      end
      WRITE: begin
        mem_cmd_en_o  = cnt_q == '0;
        wr_ack_o      = cnt_q == '0;
        mem_cmd_o     = cnt_q == '0;
        mem_addr_o    = cnt_q == '0 ? wr_addr_i : '0;
        wr_data_rd_o  = 1'b1;
        mem_wr_data_o = wr_data_i;
        beat_d        = beat_q + 1'b1;
        state_d       = beat_q == BW'(BURST_WORDS - 1) ? GAP : WRITE;
      end
      READ: begin
        mem_cmd_en_o = cnt_q == '0;
        rd_ack_o     = cnt_q == '0;
        mem_addr_o   = cnt_q == '0 ? rd_addr_i : '0;
        if (mem_rd_data_valid_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rd_data_i;
          beat_d     = beat_q + 1'b1;
          state_d    = beat_q == BW'(BURST_WORDS - 1) ? GAP : READ;
        end else if (beat_q == '0 && cnt_q == CW'(RD_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = GAP;
        end
      end
      // cnt_q counts cycles since the command; leave one cycle for IDLE to decide
      GAP: state_d = cnt_q >= CW'(CMD_GAP - 2) ? IDLE : GAP;
      default: state_d = WAIT_INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= WAIT_INIT;
      cnt_q      <= '0;
      beat_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
    end
endmodule

// File: tb/tb_psram_burst_arbiter.sv
// tb_psram_burst_arbiter: directed self-checking bench for psram_burst_arbiter.
module tb_psram_burst_arbiter;
  logic clk = 1'b0, rst_n, init_done, wr_req, rd_req, wr_ack, wr_data_rd, rd_ack;
  logic rd_data_valid, mem_cmd, mem_cmd_en, mem_rd_data_valid, error;
  logic [20:0] wr_addr, rd_addr, mem_addr;
  logic [31:0] wr_data, rd_data, mem_wr_data, mem_rd_data;
  logic [3:0] mem_data_mask;
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  psram_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n), .init_done_i(init_done),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack), .wr_data_rd_o(wr_data_rd),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ack_o(rd_ack),
    .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid),
    .mem_cmd_o(mem_cmd), .mem_cmd_en_o(mem_cmd_en), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wr_data), .mem_data_mask_o(mem_data_mask),
    .mem_rd_data_i(mem_rd_data), .mem_rd_data_valid_i(mem_rd_data_valid),
    .error_o(error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    while (mem_cmd_en !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_wait", mem_cmd_en, 1);
  endtask

  initial begin
    int n, bad, elapsed;
    logic [3:0] exp_dir;
    rst_n = 0; init_done = 0; wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0;
    wr_data = '0; mem_rd_data = '0; mem_rd_data_valid = 0;
    #1;
    chk("rst_cmd_en", mem_cmd_en, 0);
    chk("rst_wr_data_rd", wr_data_rd, 0);
    chk("rst_rd_valid", rd_data_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_error", error, 0);
    chk("rst_mask", mem_data_mask, 0);
    @(negedge clk);
    rst_n = 1; wr_req = 1; rd_req = 1; wr_addr = 21'h00100; wr_data = 32'hA0; rd_addr = 21'h1FFFF0;
    bad = 0;
    repeat (100) begin
      tick();
      if (mem_cmd_en || wr_ack || rd_ack || wr_data_rd) bad++;
    end
    chk("no_cmd_before_init", bad, 0);
    // write burst after calibration
    rd_req = 0; init_done = 1;
    tick();
    chk("init_idle_no_cmd", mem_cmd_en, 0);
    tick();
    chk("wr_cmd_en", mem_cmd_en, 1);
    chk("wr_cmd", mem_cmd, 1);
    chk("wr_addr", mem_addr, 21'h00100);
    chk("wr_ack", wr_ack, 1);
    chk("wr_beat0_rd", wr_data_rd, 1);
    chk("wr_beat0_data", mem_wr_data, 32'hA0);
    wr_req = 0;
    for (int i = 1; i < 4; i++) begin
      wr_data = 32'hA0 + i;
      tick();
      chk("wr_beat_rd", wr_data_rd, 1);
      chk("wr_beat_data", mem_wr_data, 32'hA0 + i);
      chk("wr_ack_single", wr_ack, 0);
    end
    tick();
    chk("wr_rd_end", wr_data_rd, 0);
    // read burst, beats from T+10
    rd_req = 1;
    wait_cmd(n);
    chk("wr_to_rd_spacing", n, 10);
    chk("rd_cmd", mem_cmd, 0);
    chk("rd_addr", mem_addr, 21'h1FFFF0);
    chk("rd_ack", rd_ack, 1);
    rd_req = 0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      mem_rd_data_valid = 1; mem_rd_data = 32'hB0 + i;
      if (i == 0) chk("rd_valid_before", rd_data_valid, 0);
      tick();
      chk("rd_valid", rd_data_valid, 1);
      chk("rd_data", rd_data, 32'hB0 + i);
    end
    mem_rd_data_valid = 0;
    wr_req = 1; wr_addr = 21'h00200; wr_data = 32'hC0;
    wait_cmd(n);
    chk("rd_to_wr_spacing", n, 2);
    chk("wr2_cmd", mem_cmd, 1);
    wr_req = 0;
    repeat (4) tick();
    // stray beat during GAP, then a read that times out
    rd_req = 1; rd_addr = 21'h00300; mem_rd_data_valid = 1; mem_rd_data = 32'hDEAD;
    tick();
    chk("stray_valid_discarded", rd_data_valid, 0);
    mem_rd_data_valid = 0;
    wait_cmd(n);
    chk("wr2_to_rd_spacing", n, 9);
    chk("to_rd_addr", mem_addr, 21'h00300);
    rd_req = 0;
    repeat (63) tick();
    chk("error_before_timeout", error, 0);
    wr_req = 1; wr_addr = 21'h00400;
    tick();
    chk("error_at_timeout", error, 1);
    wait_cmd(n);
    chk("timeout_to_wr", n, 2);
    chk("post_to_wr_cmd", mem_cmd, 1);
    chk("post_to_wr_addr", mem_addr, 21'h00400);
    chk("post_to_wr_rd", wr_data_rd, 1);
    chk("error_sticky", error, 1);
    // continuous requests from both sides
    rd_req = 1;
`ifdef ARB_READ_PRIORITY_EN
    exp_dir = 4'b0000;
`else
    exp_dir = 4'b1010;
`endif
    for (int g = 0; g < 4; g++) begin
      if (mem_cmd == 1'b0) begin
        for (int i = 0; i < 4; i++) begin
          tick();
          mem_rd_data_valid = 1; mem_rd_data = 32'hE0 + i;
        end
        tick();
        mem_rd_data_valid = 0;
        elapsed = 5;
      end else begin
        tick();
        elapsed = 1;
      end
      wait_cmd(n);
      chk("alt_spacing", elapsed + n, 14);
      chk("alt_dir", mem_cmd, exp_dir[g]);
    end
    // reset during write beat 2
    rd_req = 0; wr_addr = 21'h00500;
    tick();
    wait_cmd(n);
    chk("rstw_cmd", mem_cmd, 1);
    tick();
    tick();
    chk("rstw_beat2", wr_data_rd, 1);
    rst_n = 0; init_done = 0;
    #1;
    chk("rstw_cmd_en", mem_cmd_en, 0);
    chk("rstw_wr_data_rd", wr_data_rd, 0);
    chk("rstw_wr_data", mem_wr_data, 0);
    chk("rstw_error", error, 0);
    chk("rstw_rd_data", rd_data, 0);
    tick();
    rst_n = 1;
    bad = 0;
    repeat (20) begin
      tick();
      if (mem_cmd_en || wr_ack || rd_ack || wr_data_rd) bad++;
    end
    chk("rstw_quiet_until_init", bad, 0);
    init_done = 1;
    tick();
    chk("rstw_idle", mem_cmd_en, 0);
    tick();
    chk("rstw_resume_cmd_en", mem_cmd_en, 1);
    chk("rstw_resume_addr", mem_addr, 21'h00500);
    wr_req = 0;
    repeat (20) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
